// File: rtl/test_pattern_gen.sv
// test_pattern_gen: walks a FB_WIDTH x FB_HEIGHT frame and writes one
// ARGB4444 pixel per VRAM write handshake. The pattern is one of
// solid / checker / gradient / border.
// Optional feature macro: TEST_PATTERN_GEN_AUTO_REPEAT_EN. When it is defined,
// the block restarts the next frame on its own after each completed frame.
module test_pattern_gen #(
    parameter int          FB_WIDTH  = 128,
    parameter int          FB_HEIGHT = 128,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          DELAY     = 255,
    parameter int          TILE_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        vram_ack_i,
    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_mask_o,
    output logic [31:0] vram_addr_o,
    output logic [15:0] vram_data_out_o,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  frame_count_o,
    output logic [1:0]  state_o
);

    localparam int          GAP_W     = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [11:0] COL_LAST  = 12'(FB_WIDTH - 1);
    localparam logic [11:0] LINE_LAST = 12'(FB_HEIGHT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((DELAY > 0) ? DELAY - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [11:0]        col_q, col_d;
    logic [11:0]        line_q, line_d;
    logic [31:0]        addr_q, addr_d;
    logic [15:0]        data_q, data_d;
    logic               sel_q, sel_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [11:0]        bg_q, bg_d;
    logic               done_q, done_d;
    logic [7:0]         fcnt_q, fcnt_d;

    logic [11:0]        pix;
    logic [11:0]        tile_x;
    logic               last_px;

    assign last_px = (col_q == COL_LAST) && (line_q == LINE_LAST);

    // Pixel colour for the current (col, line) under the latched pattern.
    always_comb begin
        tile_x = (col_q >> TILE_LOG2) ^ (line_q >> TILE_LOG2);
        pix    = bg_q;
        case (mode_q)
            2'd0: pix = bg_q;
            2'd1: pix = tile_x[0] ? bg_q : 12'h000;
            2'd2: pix = {col_q[7:4], line_q[7:4], bg_q[3:0]};
            2'd3: pix = ((col_q == 12'd0) || (col_q == COL_LAST) ||
                         (line_q == 12'd0) || (line_q == LINE_LAST)) ? 12'hFFF : bg_q;
            default: pix = bg_q;
        endcase
    end

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        col_d   = col_q;
        line_d  = line_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        gap_d   = gap_q;
        bg_d    = bg_q;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;

        if (abort_i && (state_q != ST_IDLE)) begin
            // Coincident ack is dropped: counters, bg and frame count stay put.
            sel_d   = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        mode_d  = mode_i;
                        col_d   = 12'd0;
                        line_d  = 12'd0;
                        addr_d  = BASE_ADDR;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sel_d   = 1'b1;
                    data_d  = {4'hF, pix};
                    state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (vram_ack_i) begin
                        sel_d  = 1'b0;
                        addr_d = addr_q + 32'd1;
                        if (last_px) begin
                            col_d  = 12'd0;
                            line_d = 12'd0;
                            done_d = 1'b1;
                            fcnt_d = fcnt_q + 8'd1;
                            bg_d   = bg_q + 12'h010;
`ifdef TEST_PATTERN_GEN_AUTO_REPEAT_EN
                            addr_d = BASE_ADDR;
                            if (DELAY == 0) begin
                                state_d = ST_ISSUE;
                            end else begin
                                gap_d   = GAP_LOAD;
                                state_d = ST_GAP;
                            end
`else
                            state_d = ST_IDLE;
`endif
                        end else begin
                            if (col_q == COL_LAST) begin
                                col_d  = 12'd0;
                                line_d = line_q + 12'd1;
                            end else begin
                                col_d  = col_q + 12'd1;
                            end
                            if (DELAY == 0) begin
                                state_d = ST_ISSUE;
                            end else begin
                                gap_d   = GAP_LOAD;
                                state_d = ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            col_q   <= 12'd0;
            line_q  <= 12'd0;
            addr_q  <= 32'd0;
            data_q  <= 16'd0;
            sel_q   <= 1'b0;
            gap_q   <= '0;
            bg_q    <= 12'h00F;
            done_q  <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            col_q   <= col_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            gap_q   <= gap_d;
            bg_q    <= bg_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign vram_sel_o      = sel_q;
    assign vram_wr_o       = sel_q;
    assign vram_mask_o     = 4'hF;
    assign vram_addr_o     = addr_q;
    assign vram_data_out_o = data_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign frame_count_o   = fcnt_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: two instances (4x2 solid/gap/abort,
// 4x4 checker/border/gradient) with hand-computed expected pixels.
module tb_test_pattern_gen;

    logic clk, rst_n;

    logic        ack_a, sel_a, wr_a, start_a, abort_a, busy_a, done_a;
    logic [3:0]  mask_a;
    logic [31:0] addr_a;
    logic [15:0] data_a;
    logic [1:0]  mode_a, st_a;
    logic [7:0]  fc_a;

    logic        ack_b, sel_b, wr_b, start_b, abort_b, busy_b, done_b;
    logic [3:0]  mask_b;
    logic [31:0] addr_b;
    logic [15:0] data_b;
    logic [1:0]  mode_b, st_b;
    logic [7:0]  fc_b;

    logic [15:0] db [16];
    int n_cmp, n_bad;

    test_pattern_gen #(.FB_WIDTH(4), .FB_HEIGHT(2), .BASE_ADDR(32'h100),
                       .DELAY(2), .TILE_LOG2(3)) u_a (
        .clk(clk), .reset_i(rst_n), .vram_ack_i(ack_a), .vram_sel_o(sel_a),
        .vram_wr_o(wr_a), .vram_mask_o(mask_a), .vram_addr_o(addr_a),
        .vram_data_out_o(data_a), .start_i(start_a), .mode_i(mode_a),
        .abort_i(abort_a), .busy_o(busy_a), .done_o(done_a),
        .frame_count_o(fc_a), .state_o(st_a));

    test_pattern_gen #(.FB_WIDTH(4), .FB_HEIGHT(4), .BASE_ADDR(32'h200),
                       .DELAY(0), .TILE_LOG2(1)) u_b (
        .clk(clk), .reset_i(rst_n), .vram_ack_i(ack_b), .vram_sel_o(sel_b),
        .vram_wr_o(wr_b), .vram_mask_o(mask_b), .vram_addr_o(addr_b),
        .vram_data_out_o(data_b), .start_i(start_b), .mode_i(mode_b),
        .abort_i(abort_b), .busy_o(busy_b), .done_o(done_b),
        .frame_count_o(fc_b), .state_o(st_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_sel_a(input string tag);
        int k;
        k = 0;
        while (sel_a !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(sel_a), 32'd1);
    endtask

    task automatic wait_sel_b(input string tag);
        int k;
        k = 0;
        while (sel_b !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(sel_b), 32'd1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // One full 4x2 frame on instance A; optional ack hold-off on pixel 0.
    task automatic frame_a(input logic [15:0] exp_d, input logic [7:0] exp_fc, input int hold0);
        int c;
        for (int i = 0; i < 8; i++) begin
            wait_sel_a("a_sel");
            chk("a_wr", 32'(wr_a), 32'd1);
            chk("a_addr", addr_a, 32'(32'h100 + i));
            chk("a_data", 32'(data_a), 32'(exp_d));
            if (i == 0 && hold0 > 0) begin
                for (int h = 0; h < hold0; h++) begin
                    @(negedge clk);
                    chk("a_hold_sel", 32'(sel_a), 32'd1);
                    chk("a_hold_addr", addr_a, 32'h100);
                    chk("a_hold_data", 32'(data_a), 32'(exp_d));
                end
            end
            ack_a = 1'b1;
            @(negedge clk);
            ack_a = 1'b0;
            chk("a_sel_drop", 32'(sel_a), 32'd0);
            if (i == 0 && hold0 > 0) begin
                c = 1;
                while (sel_a !== 1'b1 && c < 20) begin
                    @(negedge clk);
                    c++;
                end
                chk("a_gap_cycles", 32'(c), 32'd4);
            end
            if (i == 7) begin
                chk("a_done", 32'(done_a), 32'd1);
                chk("a_fc", 32'(fc_a), 32'(exp_fc));
`ifdef TEST_PATTERN_GEN_AUTO_REPEAT_EN
                chk("a_busy_end", 32'(busy_a), 32'd1);
`else
                chk("a_busy_end", 32'(busy_a), 32'd0);
`endif
                @(negedge clk);
                chk("a_done_pulse", 32'(done_a), 32'd0);
            end else begin
                chk("a_no_done", 32'(done_a), 32'd0);
            end
        end
    endtask

    // One full 4x4 frame on instance B, pixels captured into db; ends idle.
    task automatic frame_b(input logic [1:0] m, input logic [7:0] exp_fc);
        mode_b  = m;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        mode_b  = 2'd0;
        for (int i = 0; i < 16; i++) begin
            wait_sel_b("b_sel");
            chk("b_addr", addr_b, 32'(32'h200 + i));
            db[i] = data_b;
            ack_b = 1'b1;
            @(negedge clk);
            ack_b = 1'b0;
        end
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_fc", 32'(fc_b), 32'(exp_fc));
        abort_b = 1'b1;
        @(negedge clk);
        abort_b = 1'b0;
        chk("b_idle", 32'(st_b), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        ack_a = 0; start_a = 0; abort_a = 0; mode_a = 2'd0;
        ack_b = 0; start_b = 0; abort_b = 0; mode_b = 2'd0;
        #2;
        chk("rst_sel", 32'(sel_a), 32'd0);
        chk("rst_wr", 32'(wr_a), 32'd0);
        chk("rst_mask", 32'(mask_a), 32'hF);
        chk("rst_addr", addr_a, 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_fc", 32'(fc_a), 32'd0);
        chk("rst_state", 32'(st_a), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: solid, bg 00F.
        pulse_start_a();
        chk("a_state_issue", 32'(st_a), 32'd1);
        chk("a_sel_issue", 32'(sel_a), 32'd0);
        frame_a(16'hF00F, 8'd1, 0);

        // Frame 2: bg advanced to 01F, ack held off on first pixel.
`ifndef TEST_PATTERN_GEN_AUTO_REPEAT_EN
        pulse_start_a();
`endif
        frame_a(16'hF01F, 8'd2, 5);

        // Frame 3: abort coincident with the ack of pixel 3.
`ifndef TEST_PATTERN_GEN_AUTO_REPEAT_EN
        pulse_start_a();
`endif
        for (int i = 0; i < 3; i++) begin
            wait_sel_a("a3_sel");
            ack_a = 1'b1;
            @(negedge clk);
            ack_a = 1'b0;
        end
        wait_sel_a("a3_sel3");
        chk("a3_addr3", addr_a, 32'h103);
        chk("a3_data3", 32'(data_a), 32'hF02F);
        ack_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        abort_a = 1'b0;
        chk("abort_sel", 32'(sel_a), 32'd0);
        chk("abort_state", 32'(st_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_fc", 32'(fc_a), 32'd2);
        repeat (3) @(negedge clk);
        chk("abort_stay_idle", 32'(busy_a), 32'd0);

        // Restart after abort begins again at the base address, same bg.
        pulse_start_a();
        wait_sel_a("re_sel");
        chk("re_addr", addr_a, 32'h100);
        chk("re_data", 32'(data_a), 32'hF02F);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("re_abort_state", 32'(st_a), 32'd0);
        chk("re_abort_fc", 32'(fc_a), 32'd2);

        // Instance B: checker with 2-pixel tiles, bg 00F.
        frame_b(2'd1, 8'd1);
        chk("chk_0", 32'(db[0]), 32'hF000);
        chk("chk_2", 32'(db[2]), 32'hF00F);
        chk("chk_3", 32'(db[3]), 32'hF00F);
        chk("chk_5", 32'(db[5]), 32'hF000);
        chk("chk_10", 32'(db[10]), 32'hF000);
        chk("chk_8", 32'(db[8]), 32'hF00F);

        // Border, bg now 01F.
        frame_b(2'd3, 8'd2);
        chk("brd_0", 32'(db[0]), 32'hFFFF);
        chk("brd_3", 32'(db[3]), 32'hFFFF);
        chk("brd_12", 32'(db[12]), 32'hFFFF);
        chk("brd_15", 32'(db[15]), 32'hFFFF);
        chk("brd_4", 32'(db[4]), 32'hFFFF);
        chk("brd_5", 32'(db[5]), 32'hF01F);
        chk("brd_10", 32'(db[10]), 32'hF01F);

        // Gradient, bg now 02F: col/line below 16 give zero upper nibbles.
        frame_b(2'd2, 8'd3);
        chk("grd_7", 32'(db[7]), 32'hF00F);
        chk("grd_15", 32'(db[15]), 32'hF00F);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        pulse_start_a();
        wait_sel_a("ar_sel");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sel", 32'(sel_a), 32'd0);
        chk("ar_addr", addr_a, 32'd0);
        chk("ar_data", 32'(data_a), 32'd0);
        chk("ar_busy", 32'(busy_a), 32'd0);
        chk("ar_fc", 32'(fc_a), 32'd0);
        chk("ar_state", 32'(st_a), 32'd0);
        chk("ar_b_fc", 32'(fc_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
